// File: rtl/pipeline_drain.sv
// -----------------------------------------------------------------------------
// pipeline_drain
// Credit-controlled drain FIFO behind a fixed-latency pipeline. Every word that
// upstream issues into the pipeline consumes one credit. The word is captured
// from the pipeline tap LAT cycles later. Popping it from the FIFO returns the
// credit. Because credits equal FIFO depth, the FIFO can never be asked to
// accept a word it has no room for.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous active-high reset
//   issue_valid  : upstream presents a new word to the pipeline input
//   issue_ready  : a credit is available (registered state only)
//   pipe_data    : pipeline output tap, WIDTH bits
//   out_valid    : FIFO head holds valid data
//   out_ready    : consumer takes the head this cycle
//   out_data     : FIFO head word
//   count        : FIFO occupancy, 0..DEPTH
//   overflow     : sticky flag, a push arrived while full with no pop
// -----------------------------------------------------------------------------
module pipeline_drain #(
  parameter int WIDTH = 8,
  parameter int LAT   = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [WIDTH-1:0]         pipe_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [LAT-1:0]   r_vsr;
  logic [CW-1:0]    r_credit;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_fire;
  logic w_pop;
  logic w_push;
  logic w_wr_en;
  logic w_drop;

  assign w_fire  = issue_valid & issue_ready;
  assign w_pop   = out_valid & out_ready;
  // The tap bit marks the cycle in which the issued word is on pipe_data.
  assign w_push  = r_vsr[LAT-1];
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_wr_en = w_push & ((r_count != FULL) | w_pop);
  assign w_drop  = w_push & (r_count == FULL) & ~w_pop;

  assign issue_ready = (r_credit != {CW{1'b0}});
  assign out_valid   = (r_count != {CW{1'b0}});
  assign out_data    = r_mem[r_rd_ptr];
  assign count       = r_count;
  assign overflow    = r_overflow;

  // In-flight tracker: one bit per pipeline stage, loaded by an accepted issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsr <= {LAT{1'b0}};
    end else begin
      r_vsr <= (r_vsr << 1) | LAT'(w_fire);
    end
  end

  // Credit counter: spent on issue, returned on pop, unchanged when both occur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= FULL;
    end else begin
      case ({w_fire, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  // FIFO occupancy and pointers; both pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= {CW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= pipe_data;
    end
  end

endmodule

// File: tb/tb_pipeline_drain.sv
// Bench for pipeline_drain: models the LAT-stage pipeline feeding pipe_data and
// checks ordering against a queue of issued words.
module tb_pipeline_drain;

  localparam int WIDTH = 8;
  localparam int LAT   = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] pipe_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             overflow;

  logic [WIDTH-1:0] pipe_q [LAT];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_w;
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  pipeline_drain #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .pipe_data(pipe_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pipeline model: data_in appears on pipe_data LAT cycles after issue.
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) pipe_q[k] <= pipe_q[k-1];
    pipe_q[0] <= data_in;
  end
  assign pipe_data = pipe_q[LAT-1];

  // One cycle: drive inputs just after the edge, sample at the falling edge,
  // and record accepted issues as expected output.
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    @(posedge clk);
    #1;
    issue_valid = iv;
    data_in     = d;
    out_ready   = ordy;
    @(negedge clk);
    if (issue_valid && issue_ready) exp_q.push_back(data_in);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, count, overflow, issue_ready} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_during: got v=%b cnt=%0d ovf=%b rdy=%b, expected v=0 cnt=0 ovf=0 rdy=1",
               out_valid, count, overflow, issue_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, count, overflow, issue_ready} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_after: got v=%b cnt=%0d ovf=%b rdy=%b, expected v=0 cnt=0 ovf=0 rdy=1",
               out_valid, count, overflow, issue_ready);
    end
  endtask

  task automatic test_single();
    for (int c = 0; c <= 12; c++) begin
      drive(c == 0, 8'hA5, 1'b1);
      if (c < 9) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL single_early: cycle %0d out_valid=%b, expected 0", c, out_valid);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
          n_err++;
          $display("FAIL single_c9: got v=%b d=%h, expected v=1 d=a5", out_valid, out_data);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (count !== 5'd0) begin
          n_err++;
          $display("FAIL single_c10_count: got %0d, expected 0", count);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL single_order: popped %h, expected nothing", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            n_err++;
            $display("FAIL single_order: popped %h, expected %h", out_data, exp_w);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_left: %0d words never popped, expected 0", exp_q.size());
    end
  endtask

  task automatic test_fill();
    for (int c = 0; c <= 39; c++) begin
      drive(c < 32, 8'(c), 1'b0);
      n_cmp++;
      if (issue_ready !== logic'(c < 16)) begin
        n_err++;
        $display("FAIL fill_ready: cycle %0d issue_ready=%b, expected %b", c, issue_ready, c < 16);
      end
      if (out_valid && exp_q.size() > 0) begin
        n_cmp++;
        if (out_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL fill_hold: cycle %0d out_data=%h, expected %h", c, out_data, exp_q[0]);
        end
      end
      if (c == 23 || c == 24) begin
        n_cmp++;
        if (count !== CW'(c - 8)) begin
          n_err++;
          $display("FAIL fill_count: cycle %0d count=%0d, expected %0d", c, count, c - 8);
        end
      end
    end
    n_cmp++;
    if (overflow !== 1'b0 || exp_q.size() != 16) begin
      n_err++;
      $display("FAIL fill_end: ovf=%b accepted=%0d, expected ovf=0 accepted=16", overflow, exp_q.size());
    end
  endtask

  task automatic test_drain();
    n_pop = 0;
    for (int c = 0; c <= 19; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (c <= 1) begin
        n_cmp++;
        if (issue_ready !== logic'(c == 1)) begin
          n_err++;
          $display("FAIL drain_ready: cycle %0d issue_ready=%b, expected %b", c, issue_ready, c == 1);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL drain_order: popped %h, expected nothing", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            n_err++;
            $display("FAIL drain_order: popped %h, expected %h", out_data, exp_w);
          end
        end
      end
    end
    n_cmp++;
    if (n_pop != 16 || count !== 5'd0) begin
      n_err++;
      $display("FAIL drain_end: pops=%0d count=%0d, expected pops=16 count=0", n_pop, count);
    end
  endtask

  task automatic test_stream();
    n_pop = 0;
    for (int c = 0; c <= 111; c++) begin
      drive(c < 100, 8'(c + 64), 1'b1);
      if (c < 100) begin
        n_cmp++;
        if (issue_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream_ready: cycle %0d issue_ready=%b, expected 1", c, issue_ready);
        end
      end
      n_cmp++;
      if (count > 5'd1) begin
        n_err++;
        $display("FAIL stream_count: cycle %0d count=%0d, expected <=1", c, count);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_order: popped %h, expected nothing", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            n_err++;
            $display("FAIL stream_order: popped %h, expected %h", out_data, exp_w);
          end
        end
      end
    end
    n_cmp++;
    if (n_pop != 100) begin
      n_err++;
      $display("FAIL stream_total: pops=%0d, expected 100", n_pop);
    end
  endtask

  task automatic test_wrap();
    logic [LAT-1:0] hist = '0;
    int m_count = 0;
    int fired   = 0;
    int inflight;
    logic fire, pop;
    n_pop = 0;
    for (int cyc = 0; cyc < 400 && n_pop < 40; cyc++) begin
      drive(fired < 40, 8'(8'h80 + fired), 1'($urandom_range(0, 1)));
      fire = issue_valid && issue_ready;
      pop  = out_valid && out_ready;
      if (fire) fired++;
      inflight = $countones(hist);
      n_cmp++;
      if (count !== CW'(m_count)) begin
        n_err++;
        $display("FAIL wrap_count: cycle %0d count=%0d, expected %0d", cyc, count, m_count);
      end
      n_cmp++;
      if (issue_ready !== logic'((DEPTH - inflight - m_count) != 0)) begin
        n_err++;
        $display("FAIL wrap_credit: cycle %0d issue_ready=%b, expected credits=%0d",
                 cyc, issue_ready, DEPTH - inflight - m_count);
      end
      if (pop) begin
        n_cmp++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wrap_order: popped %h, expected nothing", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            n_err++;
            $display("FAIL wrap_order: popped %h, expected %h", out_data, exp_w);
          end
        end
      end
      m_count = m_count + int'(hist[LAT-1]) - int'(pop);
      hist    = {hist[LAT-2:0], fire};
    end
    n_cmp++;
    if (n_pop != 40) begin
      n_err++;
      $display("FAIL wrap_timeout: pops=%0d, expected 40", n_pop);
    end
  endtask

  task automatic test_midflight();
    for (int c = 0; c <= 11; c++) begin
      drive(c < 8, 8'(8'hC0 + c), 1'b0);
    end
    n_cmp++;
    if (count !== 5'd3) begin
      n_err++;
      $display("FAIL mid_setup: count=%0d, expected 3", count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, count, issue_ready, overflow} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mid_async: got v=%b cnt=%0d rdy=%b ovf=%b, expected v=0 cnt=0 rdy=1 ovf=0",
               out_valid, count, issue_ready, overflow);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c <= 19; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_stale: cycle %0d out_valid=%b data=%h, expected 0", c, out_valid, out_data);
      end
    end
    for (int c = 0; c <= 11; c++) begin
      drive(c == 0, 8'h3C, 1'b1);
      if (c == 9) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
          n_err++;
          $display("FAIL mid_resume: got v=%b d=%h, expected v=1 d=3c", out_valid, out_data);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mid_order: popped %h, expected nothing", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            n_err++;
            $display("FAIL mid_order: popped %h, expected %h", out_data, exp_w);
          end
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    data_in     = 8'h00;
    out_ready   = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_wrap();
    test_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
